// File: rtl/sine_cosine.sv
// ---------------------------------------------------------------------------
// sine_cosine
//
// Fully pipelined CORDIC rotator. Every clock it accepts a binary angle and
// an input vector (Xin, Yin). ITER+1 clocks later it delivers that vector
// rotated by the angle and scaled by the CORDIC gain K ~= 1.6468. The gain is
// not compensated here. Loading Xin = A/1.647 and Yin = 0 gives
// Xout ~= A*cos(angle) and Yout ~= A*sin(angle).
//
// Parameters:
//   DATA_WIDTH  - signed width of Xin/Yin; outputs are one bit wider
//   ANGLE_WIDTH - width of the binary angle (4..32); 2^ANGLE_WIDTH == 360 deg
//   ITER        - number of micro-rotation stages (1..DATA_WIDTH)
//
// Ports:
//   clock     in   rising-edge clock
//   reset_n   in   synchronous active-low reset; clears every pipeline register
//   angle     in   unsigned binary angle
//   Xin, Yin  in   signed input vector
//   Xout      out  signed rotated X (DATA_WIDTH+1 bits)
//   Yout      out  signed rotated Y (DATA_WIDTH+1 bits)
//
// Optional feature, macro SINE_COSINE_VALID_EN:
//   Defining this macro adds the valid_in / valid_out ports. valid_in travels
//   through a shift register that is aligned with the data pipeline. The data
//   registers still update every cycle whatever valid_in is.
//
// Keeping K*|(Xin, Yin)| below 2^DATA_WIDTH is the caller's job. Larger
// vectors wrap silently inside the DATA_WIDTH+1 bit datapath.
// ---------------------------------------------------------------------------
module sine_cosine #(
    parameter int DATA_WIDTH  = 16,
    parameter int ANGLE_WIDTH = 32,
    parameter int ITER        = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [ANGLE_WIDTH-1:0] angle,
    input  logic [DATA_WIDTH-1:0]  Xin,
    input  logic [DATA_WIDTH-1:0]  Yin,
`ifdef SINE_COSINE_VALID_EN
    input  logic                   valid_in,
    output logic                   valid_out,
`endif
    output logic [DATA_WIDTH:0]    Xout,
    output logic [DATA_WIDTH:0]    Yout
);

    localparam int XW = DATA_WIDTH + 1;

    // Each entry is round(atan(2^-i) / (2*pi) * 2^32). The table is always
    // kept at 32-bit angle resolution. Narrower angles take the top bits.
    function automatic logic [31:0] atan_full(input int idx);
        logic [31:0] value;
        case (idx)
            0:       value = 32'h2000_0000;
            1:       value = 32'h12E4_051E;
            2:       value = 32'h09FB_385B;
            3:       value = 32'h0511_11D4;
            4:       value = 32'h028B_0D43;
            5:       value = 32'h0145_D7E1;
            6:       value = 32'h00A2_F61E;
            7:       value = 32'h0051_7C55;
            8:       value = 32'h0028_BE53;
            9:       value = 32'h0014_5F2F;
            10:      value = 32'h000A_2F98;
            11:      value = 32'h0005_17CC;
            12:      value = 32'h0002_8BE6;
            13:      value = 32'h0001_45F3;
            14:      value = 32'h0000_A2FA;
            15:      value = 32'h0000_517D;
            16:      value = 32'h0000_28BE;
            17:      value = 32'h0000_145F;
            18:      value = 32'h0000_0A30;
            19:      value = 32'h0000_0518;
            20:      value = 32'h0000_028C;
            21:      value = 32'h0000_0146;
            22:      value = 32'h0000_00A3;
            23:      value = 32'h0000_0051;
            24:      value = 32'h0000_0029;
            25:      value = 32'h0000_0014;
            26:      value = 32'h0000_000A;
            27:      value = 32'h0000_0005;
            28:      value = 32'h0000_0003;
            29:      value = 32'h0000_0001;
            30:      value = 32'h0000_0001;
            31:      value = 32'h0000_0000;
            default: value = 32'h0000_0000;
        endcase
        return value;
    endfunction

    function automatic logic [ANGLE_WIDTH-1:0] atan_entry(input int idx);
        logic [31:0] shifted;
        shifted = atan_full(idx) >> (32 - ANGLE_WIDTH);
        return shifted[ANGLE_WIDTH-1:0];
    endfunction

    // Index 0 holds the pre-rotated sample. Index i+1 holds the result of
    // micro-rotation i. Only the first ITER z values are kept, because the
    // residue left after the final stage is never used.
    logic signed [XW-1:0]          x_pipe [0:ITER];
    logic signed [XW-1:0]          y_pipe [0:ITER];
    logic signed [ANGLE_WIDTH-1:0] z_pipe [0:ITER-1];

    logic [1:0]                    quadrant;
    logic signed [XW-1:0]          xin_ext;
    logic signed [XW-1:0]          yin_ext;
    logic signed [XW-1:0]          pre_x;
    logic signed [XW-1:0]          pre_y;
    logic signed [ANGLE_WIDTH-1:0] pre_z;

    assign quadrant = angle[ANGLE_WIDTH-1:ANGLE_WIDTH-2];
    assign xin_ext  = {Xin[DATA_WIDTH-1], Xin};
    assign yin_ext  = {Yin[DATA_WIDTH-1], Yin};

    // CORDIC only converges for about +/-99.9 deg. Angles in the second and
    // third quadrants are first turned by an exact +/-90 deg, done by swapping
    // and negating. The top two angle bits are then rewritten so that the
    // remaining angle, read as signed, lies in [-90, +90). The inputs are
    // sign-extended before negation, so negating the most negative value
    // cannot overflow.
    always_comb begin
        pre_x = xin_ext;
        pre_y = yin_ext;
        pre_z = angle;
        case (quadrant)
            2'b01: begin
                pre_x = -yin_ext;
                pre_y = xin_ext;
                pre_z = {2'b00, angle[ANGLE_WIDTH-3:0]};
            end
            2'b10: begin
                pre_x = yin_ext;
                pre_y = -xin_ext;
                pre_z = {2'b11, angle[ANGLE_WIDTH-3:0]};
            end
            default: begin
            end
        endcase
    end

    // One register bank per stage. The loops unroll into constant shifts and
    // constant table entries. The sign of the remaining angle chooses the
    // rotation direction, and add/sub wraps at the datapath width.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int s = 0; s <= ITER; s++) begin
                x_pipe[s] <= '0;
                y_pipe[s] <= '0;
            end
            for (int s = 0; s < ITER; s++) begin
                z_pipe[s] <= '0;
            end
        end else begin
            x_pipe[0] <= pre_x;
            y_pipe[0] <= pre_y;
            z_pipe[0] <= pre_z;
            for (int s = 0; s < ITER; s++) begin
                if (!z_pipe[s][ANGLE_WIDTH-1]) begin
                    x_pipe[s+1] <= x_pipe[s] - (y_pipe[s] >>> s);
                    y_pipe[s+1] <= y_pipe[s] + (x_pipe[s] >>> s);
                end else begin
                    x_pipe[s+1] <= x_pipe[s] + (y_pipe[s] >>> s);
                    y_pipe[s+1] <= y_pipe[s] - (x_pipe[s] >>> s);
                end
            end
            for (int s = 0; s < ITER - 1; s++) begin
                if (!z_pipe[s][ANGLE_WIDTH-1]) begin
                    z_pipe[s+1] <= z_pipe[s] - atan_entry(s);
                end else begin
                    z_pipe[s+1] <= z_pipe[s] + atan_entry(s);
                end
            end
        end
    end

    assign Xout = x_pipe[ITER];
    assign Yout = y_pipe[ITER];

`ifdef SINE_COSINE_VALID_EN
    // valid_in is delayed by the same ITER+1 registers as the data, so
    // valid_out marks the exact cycle in which the matching result appears.
    logic [ITER:0] valid_pipe;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_pipe <= '0;
        end else begin
            valid_pipe <= {valid_pipe[ITER-1:0], valid_in};
        end
    end

    assign valid_out = valid_pipe[ITER];
`endif

endmodule

// File: tb/tb_sine_cosine.sv
// ---------------------------------------------------------------------------
// tb_sine_cosine
//
// Self-checking bench for sine_cosine in its default configuration. Each
// applied sample is turned into an ideal rotated vector using real-valued
// trigonometry and the CORDIC gain. The result visible after a given edge
// must match the sample taken ITER edges earlier, unless a reset landed in
// that window. In that case the output must be exactly zero.
// ---------------------------------------------------------------------------
module tb_sine_cosine;

    localparam int  DW   = 16;
    localparam int  AW   = 32;
    localparam int  ITER = 16;
    localparam int  TOL  = 16;
    localparam int  MAXE = 4096;
    localparam real PI   = 3.14159265358979323846;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [AW-1:0] angle;
    logic [DW-1:0] Xin;
    logic [DW-1:0] Yin;
    logic [DW:0]   Xout;
    logic [DW:0]   Yout;
`ifdef SINE_COSINE_VALID_EN
    logic          valid_in;
    logic          valid_out;
    bit            stim_valid = 1'b0;
    bit            vld_hist [MAXE];
`endif

    real exp_x    [MAXE];
    real exp_y    [MAXE];
    bit  rst_hist [MAXE];
    int  edge_num = 0;
    int  n_checks = 0;
    int  n_fail   = 0;
    real k_gain;

    logic [AW-1:0] edge_angles [8] = '{32'h0000_0000, 32'hFFFF_FFFF,
                                       32'h3FFF_FFFF, 32'h4000_0000,
                                       32'h7FFF_FFFF, 32'h8000_0000,
                                       32'hBFFF_FFFF, 32'hC000_0000};

    always #5 clock = ~clock;

    sine_cosine #(
        .DATA_WIDTH (DW),
        .ANGLE_WIDTH(AW),
        .ITER       (ITER)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .angle    (angle),
        .Xin      (Xin),
        .Yin      (Yin),
`ifdef SINE_COSINE_VALID_EN
        .valid_in (valid_in),
        .valid_out(valid_out),
`endif
        .Xout     (Xout),
        .Yout     (Yout)
    );

    // Counts every comparison. A miscompare is reported when the observed
    // value is more than tol away from the expected value.
    task automatic checkOutput(input string tag, input int observed,
                               input int expected, input int tol);
        int diff;
        n_checks = n_checks + 1;
        diff = observed - expected;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_fail = n_fail + 1;
            $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d (tol %0d)",
                     tag, edge_num, observed, expected, tol);
        end
    endtask

    function automatic logic [AW-1:0] degToAngle(input int deg);
        longint v;
        v = (longint'(deg) << 32) / 360;
        return v[AW-1:0];
    endfunction

    // Checks the outputs seen just after the current edge. The sample that
    // should be emerging now was taken ITER edges ago.
    task automatic scoreOutputs();
        int e;
        int lo;
        bit flushed;
        e       = edge_num;
        lo      = e - ITER;
        flushed = 1'b0;
        for (int k = (lo < 1) ? 1 : lo; k <= e; k++) begin
            if (rst_hist[k]) flushed = 1'b1;
        end
        if (flushed) begin
            checkOutput("xout_reset", $signed(Xout), 0, 0);
            checkOutput("yout_reset", $signed(Yout), 0, 0);
`ifdef SINE_COSINE_VALID_EN
            checkOutput("valid_reset", int'(valid_out), 0, 0);
`endif
        end else if (lo >= 1) begin
            checkOutput("xout", $signed(Xout), int'(exp_x[lo]), TOL);
            checkOutput("yout", $signed(Yout), int'(exp_y[lo]), TOL);
`ifdef SINE_COSINE_VALID_EN
            checkOutput("valid_out", int'(valid_out), int'(vld_hist[lo]), 0);
`endif
        end
    endtask

    // Drives one sample and records its ideal result. It then advances one
    // clock and scores the outputs #1 after the edge.
    task automatic applyStimulus(input logic rn, input logic [AW-1:0] a,
                                 input int xi, input int yi);
        real th;
        int  e;
        e = edge_num + 1;
        if (e >= MAXE) begin
            $display("[TB] FAIL edge_budget: edge %0d exceeds history %0d", e, MAXE);
            $fatal(1, "[TB] edge history exhausted");
        end
        reset_n = rn;
        angle   = a;
        Xin     = xi[DW-1:0];
        Yin     = yi[DW-1:0];
        th = 2.0 * PI * real'(longint'({32'd0, a})) / 4294967296.0;
        exp_x[e]    = k_gain * (real'(xi) * $cos(th) - real'(yi) * $sin(th));
        exp_y[e]    = k_gain * (real'(xi) * $sin(th) + real'(yi) * $cos(th));
        rst_hist[e] = !rn;
`ifdef SINE_COSINE_VALID_EN
        valid_in    = stim_valid;
        vld_hist[e] = stim_valid;
`endif
        @(posedge clock);
        edge_num = edge_num + 1;
        #1;
        scoreOutputs();
    endtask

    initial begin
        int step_edge;
        int seen_edge;

        k_gain = 1.0;
        for (int i = 0; i < ITER; i++) begin
            k_gain = k_gain * $sqrt(1.0 + $pow(2.0, -2.0 * i));
        end
`ifdef SINE_COSINE_VALID_EN
        valid_in = 1'b0;
`endif
        $display("[TB] sine_cosine bench, K = %f", k_gain);

        // Hold reset for a few edges, then let angle 0 settle.
        repeat (3) applyStimulus(1'b0, '0, 19429, 0);
        repeat (ITER + 4) applyStimulus(1'b1, '0, 19429, 0);

        // Step to 90 deg and measure, with a bound, when Yout first moves.
        applyStimulus(1'b1, 32'h4000_0000, 19429, 0);
        step_edge = edge_num;
        seen_edge = -1;
        for (int k = 0; k < 3 * ITER && seen_edge < 0; k++) begin
            if ($signed(Yout) > 16000) seen_edge = edge_num;
            else applyStimulus(1'b1, 32'h4000_0000, 19429, 0);
        end
        checkOutput("latency", (seen_edge < 0) ? -1 : seen_edge - step_edge + 1,
                    ITER + 1, 0);

        // Two back-to-back sweeps in 30 deg steps. The second sweep has a
        // one-cycle reset in the middle.
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 12; i++) begin
                applyStimulus((rep == 1 && i == 5) ? 1'b0 : 1'b1,
                              degToAngle(30 * i), 19429, 0);
            end
        end

        // Pure-Y input vector rotated by 90 deg.
        repeat (ITER + 3) applyStimulus(1'b1, 32'h4000_0000, 0, 19429);

        // Quadrant boundaries and the 360 deg wrap.
        foreach (edge_angles[j]) applyStimulus(1'b1, edge_angles[j], 19429, 0);

        // Random vectors, angles and occasional resets.
        for (int n = 0; n < 400; n++) begin
`ifdef SINE_COSINE_VALID_EN
            stim_valid = 1'($urandom_range(0, 1));
`endif
            applyStimulus(($urandom_range(0, 63) != 0) ? 1'b1 : 1'b0,
                          $urandom,
                          int'($urandom_range(0, 38000)) - 19000,
                          int'($urandom_range(0, 38000)) - 19000);
        end

`ifdef SINE_COSINE_VALID_EN
        // Single valid pulse surrounded by idle cycles.
        stim_valid = 1'b0;
        repeat (ITER + 2) applyStimulus(1'b1, 32'h2000_0000, 19429, 0);
        stim_valid = 1'b1;
        applyStimulus(1'b1, 32'h6000_0000, 19429, 0);
        stim_valid = 1'b0;
`endif

        // Drain the pipeline.
        repeat (ITER + 2) applyStimulus(1'b1, '0, 19429, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
